counter_snapshot_reader: RTL

// - Downstream consumer of the atomic counter: assembles a coherent COUNTLEN-bit snapshot from two back-to-back DATABUS-bit reads.
// - Read order: low word (atomic=1), then high word (atomic=0).
// - Triggered on demand (snap_req_i) or periodically (auto_en_i). Presents snapshot plus delta-since-previous on a valid/ready output.

---
 rtl/counter_rd_pkg.sv | 18 +
 rtl/counter_snapshot_reader_period_timer.sv | 30 +++
 rtl/counter_snapshot_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/counter_rd_pkg.sv
// Shared types and default widths for the counter snapshot reader.
// Holds the read FSM state encoding used by counter_snapshot_reader.
package counter_rd_pkg;

  localparam int DATABUS_DEF  = 32;
  localparam int COUNTLEN_DEF = 64;
  localparam int PERIOD_W_DEF = 16;
  localparam int DROP_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    CAP_HI = 3'd3,
    OUT    = 3'd4
  } rd_state_e;

endpackage

// File: rtl/counter_snapshot_reader_period_timer.sv
// Free-running sample timer: pulses tick once every 'period' cycles while enabled.
// Clears whenever disabled so a re-enable always starts a full period.
module period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic                at_end;

  // >= rather than == so a period shrunk below the running count still wraps
  assign at_end = (count >= (period - PERIOD_W'(1)));
  assign tick   = en && at_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en || at_end) begin
      count <= '0;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/counter_snapshot_reader.sv
// Reads an atomic counter as low word then high word and presents a coherent
// snapshot plus the delta since the previously accepted snapshot.
module counter_snapshot_reader
  import counter_rd_pkg::*;
#(
  parameter int DATABUS  = DATABUS_DEF,
  parameter int COUNTLEN = COUNTLEN_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DROP_W   = DROP_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                snap_req_i,
  input  logic                auto_en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                cnt_req_o,
  output logic                cnt_atomic_o,
  input  logic                cnt_ack_i,
  input  logic [DATABUS-1:0]  cnt_data_i,
  output logic                snap_valid_o,
  input  logic                snap_ready_i,
  output logic [COUNTLEN-1:0] snap_o,
  output logic [COUNTLEN-1:0] delta_o,
  output logic [DROP_W-1:0]   drop_cnt_o,
  output logic                err_o,
  output logic                busy_o
);

  rd_state_e           state;
  logic                auto_tick;
  logic                timer_en;
  logic                trigger;
  logic                pending;
  logic [DATABUS-1:0]  lo_word;
  logic [COUNTLEN-1:0] prev_snap;
  logic [COUNTLEN-1:0] full_word;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

  assign timer_en  = auto_en_i && (period_i != '0);
  assign trigger   = snap_req_i | auto_tick;
  assign full_word = {cnt_data_i, lo_word};

  period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (timer_en),
    .period (period_i),
    .tick   (auto_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt_req_o    <= 1'b0;
      cnt_atomic_o <= 1'b0;
      snap_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      pending      <= 1'b0;
      drop_cnt_o   <= '0;
      lo_word      <= '0;
      snap_o       <= '0;
      delta_o      <= '0;
      prev_snap    <= '0;
    end else begin
      // Triggers arriving while a read is in flight: one deep, then counted as lost
      if (trigger && (state != IDLE)) begin
        if (!pending) pending    <= 1'b1;
        else          drop_cnt_o <= sat_inc(drop_cnt_o);
      end

      case (state)
        IDLE: begin
          if (trigger || pending) begin
            state        <= RD_LO;
            cnt_req_o    <= 1'b1;
            cnt_atomic_o <= 1'b1;
            busy_o       <= 1'b1;
            // a fresh trigger coinciding with serving the pending one is kept
            pending      <= pending && trigger;
          end
        end
        RD_LO: begin
          state        <= RD_HI;
          cnt_req_o    <= 1'b1;
          cnt_atomic_o <= 1'b0;
        end
        RD_HI: begin
          cnt_req_o    <= 1'b0;
          cnt_atomic_o <= 1'b0;
          if (cnt_ack_i) begin
            lo_word <= cnt_data_i;
            state   <= CAP_HI;
          end else begin
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        CAP_HI: begin
          if (cnt_ack_i) begin
            snap_o       <= full_word;
            delta_o      <= full_word - prev_snap;
            snap_valid_o <= 1'b1;
            state        <= OUT;
          end else begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        OUT: begin
          if (snap_ready_i) begin
            prev_snap    <= snap_o;
            snap_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          cnt_req_o    <= 1'b0;
          cnt_atomic_o <= 1'b0;
          snap_valid_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
